// File: rtl/vga_capture.sv
// rtl/vga_capture.sv - VGA pixel stream capture into RGB332 framebuffer byte writes
module vga_capture #(
    parameter int H           = 640,
    parameter int V           = 480,
    parameter int PIXEL_COUNT = 307200,
    parameter bit VS_POL      = 1'b1
) (
    input  logic        clk_pixel,
    input  logic        reset_n,
    input  logic        capture_en,
    input  logic        vs,
    input  logic        de,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    output logic        wr,
    output logic [31:0] addr,
    output logic [7:0]  data,
    output logic        frame_done,
    output logic        locked,
    output logic        err_line,
    output logic        err_frame
);

    typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} state_t;

    state_t      state;
    state_t      state_next;
    logic        vs_d1;
    logic        vs_d2;
    logic        de_d1;
    logic        de_d2;
    logic [2:0]  r_d1;
    logic [2:0]  g_d1;
    logic [1:0]  b_d1;
    logic [31:0] addr_cnt;
    logic [31:0] line_cnt;
    logic [31:0] pix_cnt;
    logic        vs_act1;
    logic        vs_act2;
    logic        vs_lead;
    logic        vs_trail;
    logic        de_fall;
    logic        unused_bits;

    assign unused_bits = ^{r[4:0], g[4:0], b[5:0]};

    // vs registers reset to the inactive level so release never fakes a sync edge
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            vs_d1 <= ~VS_POL;
            vs_d2 <= ~VS_POL;
            de_d1 <= 1'b0;
            de_d2 <= 1'b0;
            r_d1  <= '0;
            g_d1  <= '0;
            b_d1  <= '0;
        end else begin
            vs_d1 <= vs;
            vs_d2 <= vs_d1;
            de_d1 <= de;
            de_d2 <= de_d1;
            r_d1  <= r[7:5];
            g_d1  <= g[7:5];
            b_d1  <= b[7:6];
        end
    end

    assign vs_act1  = (vs_d1 == VS_POL);
    assign vs_act2  = (vs_d2 == VS_POL);
    assign vs_lead  = vs_act1 & ~vs_act2;
    assign vs_trail = ~vs_act1 & vs_act2;
    assign de_fall  = ~de_d1 & de_d2;

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (vs_lead && capture_en) state_next = SYNC;
            SYNC:    if (vs_trail) state_next = ACTIVE;
            ACTIVE:  if (vs_lead) state_next = capture_en ? SYNC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            wr         <= 1'b0;
            addr       <= '0;
            data       <= '0;
            frame_done <= 1'b0;
            locked     <= 1'b0;
            err_line   <= 1'b0;
            err_frame  <= 1'b0;
            addr_cnt   <= '0;
            line_cnt   <= '0;
            pix_cnt    <= '0;
        end else begin
            wr         <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                SYNC: begin
                    if (vs_trail) begin
                        addr_cnt  <= '0;
                        line_cnt  <= '0;
                        pix_cnt   <= '0;
                        err_line  <= 1'b0;
                        err_frame <= 1'b0;
                    end
                end
                ACTIVE: begin
                    // vsync edge takes priority over a pixel arriving in the same cycle
                    if (vs_lead) begin
                        if (line_cnt == 32'(V) && !err_line && !err_frame) begin
                            frame_done <= 1'b1;
                            locked     <= 1'b1;
                        end else begin
                            locked <= 1'b0;
                            if (line_cnt != 32'(V)) err_frame <= 1'b1;
                        end
                    end else if (de_d1) begin
                        if (addr_cnt < 32'(PIXEL_COUNT)) begin
                            wr   <= 1'b1;
                            addr <= addr_cnt;
                            data <= {r_d1, g_d1, b_d1};
                        end else begin
                            err_frame <= 1'b1;
                        end
                        if (addr_cnt != '1) addr_cnt <= addr_cnt + 32'd1;
                        pix_cnt <= pix_cnt + 32'd1;
                    end else if (de_fall) begin
                        line_cnt <= line_cnt + 32'd1;
                        if (pix_cnt != 32'(H)) err_line <= 1'b1;
                        pix_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receive-side counterpart of the framebuffer VGA output.
- Takes a VGA-style pixel stream (vs, de, 24-bit RGB) on the pixel clock and decodes it back to RGB332 bytes.
- Emits a framebuffer write stream (wr/addr/data) in the same format the display's CPU write port consumes.
- Uses: loopback test, frame grabbing, and feeding an external video source into video memory.

Parameters:
- H, 640, active pixels per line
- V, 480, active lines per frame
- PIXEL_COUNT, 307200, framebuffer size in bytes; addresses at or above this are never written
- VS_POL, 1, active level of vs (1 = positive vsync)

Ports:
- clk_pixel  input  1  pixel clock; all logic on rising edge
- reset_n  input  1  asynchronous active-low reset
- capture_en  input  1  capture request, sampled only at vsync leading edge
- vs  input  1  vertical sync, polarity per VS_POL
- de  input  1  data enable, high during active pixels
- r  input  8  red
- g  input  8  green
- b  input  8  blue
- wr  output  1  framebuffer write strobe, one byte per cycle
- addr  output  32  framebuffer byte address
- data  output  8  RGB332 pixel {r[7:5], g[7:5], b[7:6]}
- frame_done  output  1  one-cycle pulse: a complete, error-free frame was written
- locked  output  1  last captured frame had exact H x V geometry
- err_line  output  1  sticky per frame: some line had a pixel count other than H
- err_frame  output  1  sticky per frame: line count other than V, or address overflow

Behaviour:
- Reset (async, reset_n low):
  - Outputs: wr=0, addr=0, data=0, frame_done=0, locked=0, err_line=0, err_frame=0.
  - Internal: state=IDLE, line/pixel counters=0.
  - Reset mid-frame aborts the frame immediately; no further writes until a new vsync cycle.
- Input stage:
  - vs, de, r, g, b registered once (stage d1), then once more for edge detect (d2).
  - Edges are computed from d1 vs d2; vs is normalised by VS_POL.
- Latency: a pixel presented with de=1 at the pins produces wr=1 exactly 2 clk_pixel cycles later. wr is fully registered.
- States:
  - IDLE: ignore everything until the vsync leading edge. There, if capture_en=1, go to SYNC; otherwise stay in IDLE.
  - SYNC: on the vsync trailing edge, clear addr, line and pixel counters and err flags, then go to ACTIVE.
  - ACTIVE:
    - Each cycle with d1.de=1: wr=1, data=RGB332(d1), addr=running address, running address +1, pixel counter +1.
    - On the de falling edge: line counter +1; if pixel counter != H, set err_line; clear pixel counter.
    - On the vsync leading edge: evaluate the frame (below), then go to SYNC if capture_en=1, otherwise IDLE.
- Frame evaluation at the vsync leading edge:
  - If line counter == V and err_line=0 and err_frame=0: frame_done=1 for one cycle, locked=1.
  - Otherwise: set err_frame if line counter != V, locked=0, no frame_done.
  - err flags hold their values until cleared at the next SYNC→ACTIVE transition.
- Overflow: a write whose running address >= PIXEL_COUNT is suppressed (wr=0) and sets err_frame. The address counter keeps counting, saturating at 2^32-1.
- Outside ACTIVE: wr=0; data and addr hold their last values.
- Simultaneous de=1 and vsync leading edge in the same d1 cycle: the vsync edge wins; the pixel is not written.
- Power-up mid-frame: the first partial frame is never written. Capture starts only after a full vsync pulse has been seen (IDLE→SYNC→ACTIVE).
- capture_en changes mid-frame have no effect until the next vsync leading edge.

Test Plan:
- Standard 640x480 timing, VS_POL=1, capture_en=1, two frames:
  - Frame 2 yields exactly 307200 wr pulses with addr 0..307199 in order.
  - frame_done pulses once at the following vsync; locked=1, err_line=0, err_frame=0.
- Colour decode:
  - r=8'hE0, g=8'h1C, b=8'hC0 → data=8'hE3.
  - r=8'h20, g=8'hFF, b=8'h40 → data=8'h3D.
  - wr appears 2 cycles after de.
- Line 100 carries 639 pixels:
  - err_line=1, err_frame=0 at frame end.
  - No frame_done; locked falls to 0.
  - Next good frame restores locked=1 with a frame_done pulse.
- 481-line frame:
  - Writes for addr >= 307200 are suppressed.
  - err_frame=1, locked=0, no frame_done.
- Reset asserted after 1000 writes, then released during active video:
  - All outputs are 0 immediately.
  - No wr until after the next complete vsync pulse; that frame then starts again at addr 0.
- capture_en=0 sampled at a vsync leading edge:
  - Zero writes in the following frame.
  - Raising capture_en mid-frame has no effect until the next vsync.
